// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle joining the processor port, the loader/debug port, the data
// memory and the I/O word to mem_bus_arbiter.
interface mem_bus_arbiter_if #(
  parameter int NBITS = 8
);
  logic             p_req;
  logic             p_we;
  logic [NBITS-3:0] p_addr;
  logic [NBITS-1:0] p_wdata;
  logic [NBITS-1:0] p_rdata;
  logic             p_ready;

  logic             d_req;
  logic             d_we;
  logic [NBITS-3:0] d_addr;
  logic [NBITS-1:0] d_wdata;
  logic [NBITS-1:0] d_rdata;
  logic             d_ready;

  logic [NBITS-3:0] m_addr;
  logic [NBITS-1:0] m_wdata;
  logic             m_wren;
  logic [NBITS-1:0] m_q;

  logic [NBITS-1:0] entrada;
  logic [NBITS-1:0] saida;
  logic             interrupt;
  logic             int_ack;

  // The arbiter side: serves both requesters, drives memo and the I/O word.
  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output m_addr, m_wdata, m_wren,
    input  m_q,
    input  entrada, int_ack,
    output saida, interrupt
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  m_addr, m_wdata, m_wren,
    output m_q,
    output entrada, int_ack,
    input  saida, interrupt
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin sequencer sharing the single-port data memory and the I/O word
// between the processor and the loader/debug port, plus the entrada interrupt.
module mem_bus_arbiter #(
  parameter int               NBITS  = 8,
  parameter logic [NBITS-3:0] IOADDR = 'h3F
) (
  input logic              clock,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int AW = NBITS - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DATA, DONE} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic [NBITS-1:0] p_rdata_q, p_rdata_d;
  logic [NBITS-1:0] d_rdata_q, d_rdata_d;
  logic             p_ready_q, p_ready_d;
  logic             d_ready_q, d_ready_d;
  logic [AW-1:0]    m_addr_q, m_addr_d;
  logic [NBITS-1:0] m_wdata_q, m_wdata_d;
  logic             m_wren_q, m_wren_d;
  logic [NBITS-1:0] saida_q, saida_d;
  logic [NBITS-1:0] guarda_ent_q, guarda_ent_d;
  logic             interrupt_q, interrupt_d;

  logic             grant_loader;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [NBITS-1:0] sel_wdata;
  logic             finish;

  // last_q = 1 means the loader was served most recently, so the processor wins a tie.
  assign grant_loader = bus.d_req && (!bus.p_req || !last_q);
  assign sel_we       = grant_loader ? bus.d_we    : bus.p_we;
  assign sel_addr     = grant_loader ? bus.d_addr  : bus.p_addr;
  assign sel_wdata    = grant_loader ? bus.d_wdata : bus.p_wdata;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p_rdata_d    = p_rdata_q;
    d_rdata_d    = d_rdata_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wren_d     = 1'b0;
    saida_d      = saida_q;
    guarda_ent_d = bus.entrada;
    interrupt_d  = interrupt_q;
    finish       = 1'b0;

    if (bus.entrada != guarda_ent_q) begin
      interrupt_d = 1'b1;
    end else if (bus.int_ack) begin
      interrupt_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.p_req || bus.d_req) begin
          gnt_d   = grant_loader;
          last_d  = grant_loader;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // memo pins are registered here so they are valid throughout ACCESS
          if (sel_addr != IOADDR) begin
            m_addr_d  = sel_addr;
            m_wdata_d = sel_wdata;
            m_wren_d  = sel_we;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (addr_q == IOADDR) begin
          if (we_q) begin
            saida_d = wdata_q;
          end else if (gnt_q) begin
            d_rdata_d = bus.entrada;
          end else begin
            p_rdata_d = bus.entrada;
          end
          finish  = 1'b1;
          state_d = DONE;
        end else if (we_q) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (gnt_q) begin
          d_rdata_d = bus.m_q;
        end else begin
          p_rdata_d = bus.m_q;
        end
        finish  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    p_ready_d = finish && !gnt_q;
    d_ready_d = finish && gnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p_rdata_q    <= '0;
      d_rdata_q    <= '0;
      p_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wren_q     <= 1'b0;
      saida_q      <= '0;
      guarda_ent_q <= '0;
      interrupt_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p_rdata_q    <= p_rdata_d;
      d_rdata_q    <= d_rdata_d;
      p_ready_q    <= p_ready_d;
      d_ready_q    <= d_ready_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wren_q     <= m_wren_d;
      saida_q      <= saida_d;
      guarda_ent_q <= guarda_ent_d;
      interrupt_q  <= interrupt_d;
    end
  end

  assign bus.p_rdata   = p_rdata_q;
  assign bus.p_ready   = p_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_wren    = m_wren_q;
  assign bus.saida     = saida_q;
  assign bus.interrupt = interrupt_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two-port traffic scored against a transaction-level
// model of round-robin order, memory contents, I/O word and completion cycles.
module tb_mem_bus_arbiter;
  localparam int NBITS = 8;
  localparam int AW = NBITS - 2;
  localparam logic [AW-1:0] IOADDR = 6'h3F;

  typedef struct {
    logic [NBITS-1:0] rdata;
    logic [NBITS-1:0] saida;
    int               cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wren_cycles = 0;
  int exp_writes = 0;

  logic [NBITS-1:0] memo_arr [1<<AW];
  logic [NBITS-1:0] ref_mem [1<<AW];
  logic [NBITS-1:0] ref_rdata [2];
  logic [NBITS-1:0] ref_saida;
  logic             ref_last;
  exp_t             exp_q [2][$];

  mem_bus_arbiter_if #(.NBITS(NBITS)) bus ();

  mem_bus_arbiter #(.NBITS(NBITS), .IOADDR(IOADDR)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [NBITS-1:0] init_word(input int i);
    return NBITS'(i * 37 + 11);
  endfunction

  // Synchronous single-port memo: q follows the address sampled at the previous edge.
  initial begin
    for (int i = 0; i < (1 << AW); i++) memo_arr[i] = init_word(i);
    bus.m_q = '0;
    forever begin
      @(posedge clock);
      bus.m_q <= memo_arr[bus.m_addr];
      if (bus.m_wren) memo_arr[bus.m_addr] <= bus.m_wdata;
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_p_rdata"}, bus.p_rdata, 0);
    check({tag, "_d_rdata"}, bus.d_rdata, 0);
    check({tag, "_p_ready"}, bus.p_ready, 0);
    check({tag, "_d_ready"}, bus.d_ready, 0);
    check({tag, "_m_addr"}, bus.m_addr, 0);
    check({tag, "_m_wdata"}, bus.m_wdata, 0);
    check({tag, "_m_wren"}, bus.m_wren, 0);
    check({tag, "_saida"}, bus.saida, 0);
    check({tag, "_interrupt"}, bus.interrupt, 0);
  endtask

  task automatic checkPort(input int port, input logic [NBITS-1:0] rdata);
    exp_t  e;
    string nm;
    nm = (port != 0) ? "d" : "p";
    check({nm, "_ready_expected"}, exp_q[port].size() != 0, 1);
    if (exp_q[port].size() != 0) begin
      e = exp_q[port].pop_front();
      check({nm, "_rdata"}, rdata, e.rdata);
      check({nm, "_ready_cycle"}, cyc, e.cyc);
      check({nm, "_saida_at_ready"}, bus.saida, e.saida);
    end
  endtask

  // Monitor: every ready pulse is matched against the oldest expectation of that port.
  always @(negedge clock) begin
    if (bus.m_wren) wren_cycles++;
    if (bus.p_ready) checkPort(0, bus.p_rdata);
    if (bus.d_ready) checkPort(1, bus.d_rdata);
  end

  function automatic logic [AW-1:0] randAddr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return IOADDR;
    if (r == 1) return AW'(62);
    return AW'($urandom_range(0, 7));
  endfunction

  // Reference: one transaction served at 'start' finishes after a fixed latency.
  function automatic int modelTxn(input bit ld, input bit we, input logic [AW-1:0] addr,
                                  input logic [NBITS-1:0] wd, input int start);
    exp_t e;
    int   lat;
    ref_last = ld;
    if (we) begin
      lat = 2;
      if (addr == IOADDR) begin
        ref_saida = wd;
      end else begin
        ref_mem[addr] = wd;
        exp_writes++;
      end
    end else if (addr == IOADDR) begin
      lat = 2;
      ref_rdata[ld] = bus.entrada;
    end else begin
      lat = 3;
      ref_rdata[ld] = ref_mem[addr];
    end
    e.rdata = ref_rdata[ld];
    e.saida = ref_saida;
    e.cyc   = start + lat;
    exp_q[ld].push_back(e);
    return start + lat + 1;
  endfunction

  task automatic applyStimulus(input bit p_do, input bit p_we, input logic [AW-1:0] p_addr,
                               input logic [NBITS-1:0] p_wd,
                               input bit d_do, input bit d_we, input logic [AW-1:0] d_addr,
                               input logic [NBITS-1:0] d_wd, input int gap);
    bit first_ld;
    bit p_pend;
    bit d_pend;
    int start;
    int budget;
    first_ld = (p_do && d_do) ? !ref_last : d_do;
    start = cyc;
    if (first_ld) begin
      if (d_do) start = modelTxn(1'b1, d_we, d_addr, d_wd, start);
      if (p_do) start = modelTxn(1'b0, p_we, p_addr, p_wd, start);
    end else begin
      if (p_do) start = modelTxn(1'b0, p_we, p_addr, p_wd, start);
      if (d_do) start = modelTxn(1'b1, d_we, d_addr, d_wd, start);
    end
    bus.p_req = p_do; bus.p_we = p_we; bus.p_addr = p_addr; bus.p_wdata = p_wd;
    bus.d_req = d_do; bus.d_we = d_we; bus.d_addr = d_addr; bus.d_wdata = d_wd;
    p_pend = p_do;
    d_pend = d_do;
    budget = 0;
    while ((p_pend || d_pend) && budget < 40) begin
      @(negedge clock);
      budget++;
      if (p_pend && bus.p_ready) begin bus.p_req = 1'b0; p_pend = 1'b0; end
      if (d_pend && bus.d_ready) begin bus.d_req = 1'b0; d_pend = 1'b0; end
    end
    check("round_complete", p_pend || d_pend, 0);
    bus.p_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (gap + 1) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned sel;
    bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.entrada = '0;
    bus.int_ack = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_saida = '0;
    ref_last = 1'b1;

    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset");
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] contention from reset, back-to-back reads");
    applyStimulus(1'b1, 1'b0, 6'd10, 8'h00, 1'b1, 1'b0, 6'd20, 8'h00, 0);
    applyStimulus(1'b1, 1'b0, 6'd11, 8'h00, 1'b1, 1'b0, 6'd21, 8'h00, 0);

    $display("[TB] processor write then read of address 5");
    applyStimulus(1'b1, 1'b1, 6'd5, 8'hA5, 1'b0, 1'b0, 6'd0, 8'h00, 1);
    applyStimulus(1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1);

    $display("[TB] I/O word access");
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, IOADDR, 8'h3C, 0);
    bus.entrada = 8'h81;
    applyStimulus(1'b1, 1'b0, IOADDR, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) bus.entrada = NBITS'($urandom);
      applyStimulus(sel[0], 1'($urandom_range(0, 1)), randAddr(), NBITS'($urandom),
                    sel[1], 1'($urandom_range(0, 1)), randAddr(), NBITS'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("[TB] interrupt sequence");
    bus.entrada = 8'h00;
    repeat (2) @(negedge clock);
    bus.int_ack = 1'b1;
    @(negedge clock);
    bus.int_ack = 1'b0;
    check("int_cleared", bus.interrupt, 0);
    bus.entrada = 8'h01;
    @(negedge clock);
    check("int_set", bus.interrupt, 1);
    @(negedge clock);
    check("int_hold_stable", bus.interrupt, 1);
    bus.int_ack = 1'b1;
    @(negedge clock);
    bus.int_ack = 1'b0;
    check("int_ack_clears", bus.interrupt, 0);
    bus.entrada = 8'h02;
    bus.int_ack = 1'b1;
    @(negedge clock);
    bus.int_ack = 1'b0;
    check("int_set_beats_ack", bus.interrupt, 1);
    @(negedge clock);
    check("int_sticky", bus.interrupt, 1);

    $display("[TB] reset during DATA of a read");
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 6'd9; bus.d_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bus.p_req = 1'b0;
    #1 checkOutput("abort");
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_saida = '0;
    ref_last = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("abort_no_p_ready", bus.p_ready, 0);
    end
    reset = 1'b1;
    @(negedge clock);
    check("int_after_reset", bus.interrupt, 1);
    applyStimulus(1'b1, 1'b0, 6'd9, 8'h00, 1'b1, 1'b0, 6'd3, 8'h00, 1);

    check("p_queue_drained", exp_q[0].size(), 0);
    check("d_queue_drained", exp_q[1].size(), 0);
    check("m_wren_cycles", wren_cycles, exp_writes);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
